// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on input and output, carry/overflow flags,
// a tag pass-through and an iterative shift-add multiplier that stalls the input while it runs.
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] out_tag,
   output logic             zero,
   output logic             lt,
   output logic             carry,
   output logic             ovf
);

   // state      | meaning
   // S_IDLE     | single-cycle ops accepted; MUL accepted and started
   // S_MUL_BUSY | shift-add multiply running, input stalled
   typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [WIDTH-1:0]  WIDTH_V  = WIDTH'(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_HAM = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_SRL = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_PSA = 4'd7;
   localparam logic [3:0] OP_SLL = 4'd8;
   localparam logic [3:0] OP_SRA = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_SLT = 4'd11;

   state_t state_q, state_d;

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] mtag_q, mtag_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             zero_q, zero_d;
   logic             lt_q, lt_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic             accept;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] acc_step;

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH-1:0] ham;
   logic             sh_big;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (mul_start) state_d = S_MUL_BUSY;
         S_MUL_BUSY: if (cnt_q == '0) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = !reset && (state_q == S_IDLE) && (!valid_q || out_ready);
      mul_done = (state_q == S_MUL_BUSY) && (cnt_q == '0);
   end

   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (alu_control == OP_MUL);

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};
   assign sh_big = (b >= WIDTH_V);

   always_comb begin
      ham = '0;
      for (int i = 0; i < WIDTH; i++) ham = ham + WIDTH'(a[i] ^ b[i]);
   end

   // Opcodes 12-15 fall through to ADD along with 0.
   always_comb begin
      alu_res   = sum_w[WIDTH-1:0];
      alu_carry = sum_w[WIDTH];
      alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      case (alu_control)
         OP_SUB: begin
            alu_res   = diff_w[WIDTH-1:0];
            alu_carry = ~diff_w[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_HAM, OP_XOR, OP_SRL, OP_AND, OP_OR, OP_PSA, OP_SLL, OP_SRA, OP_MUL, OP_SLT: begin
            alu_carry = 1'b0;
            alu_ovf   = 1'b0;
            case (alu_control)
               OP_HAM:  alu_res = ham;
               OP_XOR:  alu_res = a ^ b;
               OP_SRL:  alu_res = sh_big ? '0 : (a >> b);
               OP_AND:  alu_res = a & b;
               OP_OR:   alu_res = a | b;
               OP_PSA:  alu_res = a;
               OP_SLL:  alu_res = sh_big ? '0 : (a << b);
               OP_SRA:  alu_res = sh_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
               OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
               default: alu_res = '0;
            endcase
         end
         default: ;
      endcase
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mtag_d   = mtag_q;
      if (mul_start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = CNT_LAST;
         mtag_d   = in_tag;
      end else if (state_q == S_MUL_BUSY) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_step;
         cnt_d    = cnt_q - 1'b1;
      end
   end

   // A MUL only starts once the output stage is empty or draining, so mul_done never overwrites.
   always_comb begin
      result_d = result_q;
      tag_d    = tag_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      zero_d   = zero_q;
      lt_d     = lt_q;
      if (mul_done) begin
         result_d = acc_step;
         tag_d    = mtag_q;
         carry_d  = 1'b0;
         ovf_d    = 1'b0;
         valid_d  = 1'b1;
      end else if (accept && !mul_start) begin
         result_d = alu_res;
         tag_d    = in_tag;
         carry_d  = alu_carry;
         ovf_d    = alu_ovf;
         valid_d  = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d  = 1'b0;
      end
      if (mul_done || (accept && !mul_start)) begin
         zero_d = (result_d == '0);
         lt_d   = result_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mtag_q   <= '0;
         result_q <= '0;
         tag_q    <= '0;
         zero_q   <= 1'b0;
         lt_q     <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mtag_q   <= mtag_d;
         result_q <= result_d;
         tag_q    <= tag_d;
         zero_q   <= zero_d;
         lt_q     <= lt_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign result    = result_q;
   assign out_tag   = tag_q;
   assign zero      = zero_q;
   assign lt        = lt_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are queued at accept and compared
// in order as the output handshake completes.
module tb_alu_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  alu_control;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  out_tag;
   logic        zero;
   logic        lt;
   logic        carry;
   logic        ovf;

   alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_control(alu_control), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_tag(out_tag),
      .zero(zero), .lt(lt), .carry(carry), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  tag;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [23:0] obs;
   assign obs = {result, out_tag, zero, lt, carry, ovf};

   // {op, a, b}
   logic [35:0] dir_tbl [0:14] = '{
      {4'd0,  16'hFFFF, 16'h0001},
      {4'd1,  16'h8000, 16'h0001},
      {4'd11, 16'hFFFF, 16'h0001},
      {4'd2,  16'h00FF, 16'h0F0F},
      {4'd4,  16'h8000, 16'h000F},
      {4'd9,  16'h8000, 16'h0014},
      {4'd8,  16'h0001, 16'h0010},
      {4'd0,  16'h7FFF, 16'h0001},
      {4'd3,  16'hA5A5, 16'h0FF0},
      {4'd5,  16'hF0F0, 16'h3C3C},
      {4'd6,  16'hF000, 16'h000F},
      {4'd7,  16'h1234, 16'h0000},
      {4'd13, 16'h0003, 16'h0004},
      {4'd9,  16'h8000, 16'h0004},
      {4'd11, 16'h0001, 16'hFFFF}
   };

   function automatic exp_t model(input logic [3:0] op, input logic [15:0] xa,
                                  input logic [15:0] xb, input logic [3:0] tg);
      exp_t        e;
      int unsigned ua, ub;
      int          sa, sb, r;
      logic        c, v;
      ua = xa; ub = xb;
      sa = int'($signed(xa)); sb = int'($signed(xb));
      c = 1'b0; v = 1'b0;
      case (op)
         4'd1: begin
            r = int'(ua) - int'(ub);
            c = (ua >= ub);
            v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
         end
         4'd2:  r = $countones(xa ^ xb);
         4'd3:  r = int'(ua ^ ub);
         4'd4:  r = (ub >= 16) ? 0 : int'(ua >> ub);
         4'd5:  r = int'(ua & ub);
         4'd6:  r = int'(ua | ub);
         4'd7:  r = int'(ua);
         4'd8:  r = (ub >= 16) ? 0 : int'(ua << ub);
         4'd9:  r = (ub >= 16) ? (xa[15] ? -1 : 0) : (sa >>> ub);
         4'd10: r = int'(ua * ub);
         4'd11: r = (sa < sb) ? 1 : 0;
         default: begin
            r = int'(ua + ub);
            c = (ua + ub) > 65535;
            v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
         end
      endcase
      e.res = r[15:0];
      e.tag = tg;
      e.z   = (r[15:0] == 16'h0000);
      e.n   = r[15];
      e.c   = c;
      e.v   = v;
      return e;
   endfunction

   function automatic logic [35:0] rand_item();
      logic [3:0]  op;
      logic [15:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      return {op, ra, rb};
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      alu_control = 4'd0; a = '0; b = '0; in_tag = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      else n_pass++;
      n_checks++;
      if ({obs, out_valid} !== 25'h0) $display("FAIL reset_outputs: got %h, required 0", {obs, out_valid});
      else n_pass++;
      reset = 1'b0; #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_ops_stream(input bit directed, input int n, input bit rnd_ready);
      int          issued = 0;
      int          cycles = 0;
      int          stalls = 0;
      exp_t        e;
      logic [35:0] item;
      item = directed ? dir_tbl[0] : rand_item();
      while ((issued < n || sb_q.size() != 0 || out_valid) && cycles < 3000) begin
         @(negedge clk);
         in_valid = (issued < n);
         {alu_control, a, b} = item;
         in_tag = 4'(issued);
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL stream_unexpected: got %h, required no output", obs);
            else begin
               e = sb_q.pop_front();
               if (obs !== e) $display("FAIL stream_result: got %h, required %h", obs, e);
               else n_pass++;
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(alu_control, a, b, in_tag));
            issued++;
            if (issued < n) item = directed ? dir_tbl[issued] : rand_item();
         end else if (in_valid) stalls++;
         cycles++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (cycles >= 3000 || sb_q.size() != 0)
         $display("FAIL stream_drain: got %0d pending after %0d cycles, required 0", sb_q.size(), cycles);
      else n_pass++;
      if (directed && !rnd_ready) begin
         n_checks++;
         if (stalls != 0) $display("FAIL stream_throughput: got %0d stalls, required 0", stalls);
         else n_pass++;
      end
      sb_q.delete();
   endtask

   task automatic test_mul_stall();
      int   guard = 0;
      int   j = 0;
      int   low_cnt = 0;
      exp_t e;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      alu_control = 4'd10; a = 16'h0123; b = 16'h0010; in_tag = 4'd5;
      #1;
      while (!in_ready && guard < 20) begin
         @(negedge clk); #1; guard++;
      end
      @(negedge clk);
      alu_control = 4'd0; a = 16'h0003; b = 16'h0004; in_tag = 4'd6;
      #1;
      while (!out_valid && j < 40) begin
         if (!in_ready) low_cnt++;
         @(negedge clk); #1; j++;
      end
      n_checks++;
      if (j != 16) $display("FAIL mul_latency: got %0d cycles, required 16", j);
      else n_pass++;
      n_checks++;
      if (low_cnt != 16) $display("FAIL mul_in_ready_low: got %0d cycles, required 16", low_cnt);
      else n_pass++;
      e = model(4'd10, 16'h0123, 16'h0010, 4'd5);
      n_checks++;
      if (obs !== e || result !== 16'h1230 || out_tag !== 4'd5)
         $display("FAIL mul_result: got %h, required %h", obs, e);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL mul_drain_ready: got %b, required 1", in_ready);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      e = model(4'd0, 16'h0003, 16'h0004, 4'd6);
      n_checks++;
      if (!out_valid || obs !== e) $display("FAIL mul_held_add: got %b/%h, required 1/%h", out_valid, obs, e);
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL mul_after_drain_valid: got %b, required 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [35:0] items [0:2];
      int          idx = 0;
      int          cyc = 0;
      exp_t        e;
      items[0] = {4'd0, 16'h1234, 16'h1111};
      items[1] = {4'd0, 16'h7FFF, 16'h0001};
      items[2] = {4'd0, 16'h8000, 16'h8000};
      while ((idx < 3 || sb_q.size() != 0 || out_valid) && cyc < 40) begin
         @(negedge clk);
         out_ready = (cyc >= 6);
         in_valid  = (idx < 3);
         if (idx < 3) {alu_control, a, b} = items[idx];
         in_tag = 4'(idx + 8);
         #1;
         if (out_valid && !out_ready && sb_q.size() != 0) begin
            n_checks++;
            if (obs !== sb_q[0]) $display("FAIL bp_hold_stable: got %h, required %h", obs, sb_q[0]);
            else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready);
            else n_pass++;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL bp_unexpected: got %h, required no output", obs);
            else begin
               e = sb_q.pop_front();
               if (obs !== e) $display("FAIL bp_result: got %h, required %h", obs, e);
               else n_pass++;
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(model(alu_control, a, b, in_tag));
            idx++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (idx != 3 || sb_q.size() != 0)
         $display("FAIL bp_drain: got %0d issued %0d pending, required 3 issued 0 pending", idx, sb_q.size());
      else n_pass++;
      sb_q.delete();
   endtask

   task automatic test_reset_during_mul();
      int guard = 0;
      int seen = 0;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      alu_control = 4'd10; a = 16'h00FF; b = 16'h00FF; in_tag = 4'd9;
      #1;
      while (!in_ready && guard < 20) begin
         @(negedge clk); #1; guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1; #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL rst_mul_in_ready: got %b, required 0", in_ready);
      else n_pass++;
      repeat (2) @(negedge clk);
      reset = 1'b0; #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL rst_mul_idle: got %b, required 1", in_ready);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen++;
         @(negedge clk); #1;
      end
      n_checks++;
      if (seen != 0) $display("FAIL rst_mul_no_result: got %0d valid cycles, required 0", seen);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ops_stream(1'b1, 15, 1'b0);
      test_mul_stall();
      test_backpressure();
      test_reset_during_mul();
      test_ops_stream(1'b0, 60, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
